ring_counter: RTL and testbench
===============================

# ring_counter

One-hot ring counter: a single set bit circulates through a WIDTH-bit register, advancing one position per clock. It serves as a simple phase/slot sequencer (time-slot select, round-robin strobes, stepper phases) and is a leaf block with no handshake. Default configuration is 4 bits with the token starting at bit 0.

## Interface

Parameters:
- WIDTH, default 4: number of ring positions; legal range 2..32.
- RESET_VALUE, default 1 (WIDTH'b0…01): value loaded on reset; must be one-hot.

Ports, in positional order `clk, reset, q`:
- clk, input, 1: sole clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- q, output, WIDTH: ring state, driven directly from the state register.

## Operation

- State register `q` has WIDTH bits and is the only storage.
- Reset asserted (level): `q` = RESET_VALUE immediately, without waiting for a clock edge. It holds there for as long as reset stays high, ignoring clk.
- Reset low, each rising clk edge: rotate left by one: `q <= {q[WIDTH-2:0], q[WIDTH-1]}`.
- Wrap-around: when bit WIDTH-1 is set, the next edge moves the token to bit 0.
- Default sequence from reset (WIDTH=4): 0001 → 0010 → 0100 → 1000 → 0001 → …; period = WIDTH cycles.
- Reset mid-sequence: the ring returns to RESET_VALUE asynchronously from any state, and the sequence restarts from position 0 after release.
- Non-one-hot state (e.g. after an SEU, or an illegal RESET_VALUE): behaviour is set by the Configuration macro.
- Outputs are registered only, with no combinational path from input to output.

## Timing

- Reset assertion to `q` = RESET_VALUE: zero clock cycles (asynchronous clear/preset).
- Reset release: the first rotation occurs on the first rising edge at which reset is sampled low. Reset deassertion is expected to be synchronized upstream.
- Latency: 1 clock per position; `q` updates only on rising clk edges.
- Reset and clk edge arriving together: reset dominates, and `q` = RESET_VALUE.

## Configuration

- Macro `RING_COUNTER_SELF_CORRECT_EN`.
- Defined:
  - on each rising edge with reset low, if `q` is not exactly one-hot (zero bits set, or more than one bit set), load RESET_VALUE instead of rotating;
  - the one-hot check is combinational (popcount == 1);
  - recovery takes exactly one clock.
- Undefined:
  - pure rotation, with no check;
  - an all-zero state stays all-zero;
  - a multi-hot state rotates unchanged.

## Test plan

- Reset assertion: clk period 10, reset=1 from t=0 → `q`=0001 at t=0, before any edge, and stays 0001 through the edge at t=5.
- Free run: reset=0 at t=10; rising edges at t=15, 25, 35, 45, 55 → `q` = 0010, 0100, 1000, 0001, 0010.
- Asynchronous mid-run reset: reset=1 at t=60, between edges → `q`=0001 immediately at t=60; stays 0001 at the edge at t=65.
- Second release: reset=0 at t=70; edges at t=75, 85, 95, 105, 115 → 0010, 0100, 1000, 0001, 0010. This confirms a clean restart and wrap-around.
- Self-correction (macro defined): force `q`=0110 with reset low → next edge gives `q`=0001. Force `q`=0000 → next edge gives 0001. With the macro undefined, 0110 → 1100 and 0000 → 0000.
- Parameter check: WIDTH=8, RESET_VALUE=8'h01, run 9 edges → 02, 04, 08, 10, 20, 40, 80, 01, 02.

Source files
------------

// File: rtl/ring_counter.sv
// ring_counter: one-hot token rotating left one position per rising clk edge.
// Define RING_COUNTER_SELF_CORRECT_EN to reload RESET_VALUE from any non-one-hot state.
module ring_counter #(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_next;

`ifdef RING_COUNTER_SELF_CORRECT_EN
  logic [5:0] ones;

  // Popcount of the ring; anything other than exactly one set bit is a corrupted token.
  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones = ones + 6'(q[i]);
    end
    q_next = (ones == 6'd1) ? {q[WIDTH-2:0], q[WIDTH-1]} : RESET_VALUE;
  end
`else
  always_comb begin
    q_next = {q[WIDTH-2:0], q[WIDTH-1]};
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: tb/tb_ring_counter.sv
// Scoreboard bench for ring_counter: default 4-bit ring, 8-bit ring, and two
// illegal RESET_VALUE rings (multi-hot and all-zero) sharing one clk/reset.
module tb_ring_counter;

  logic       clk;
  logic       reset;
  logic [3:0] q4;
  logic [7:0] q8;
  logic [3:0] qmh;
  logic [3:0] qz;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic [3:0] e4;
    logic [7:0] e8;
    logic [3:0] emh;
    logic [3:0] ez;
  } exp_t;

  exp_t sb[$];

  ring_counter u4 (.clk(clk), .reset(reset), .q(q4));

  ring_counter #(.WIDTH(8), .RESET_VALUE(8'h01)) u8 (.clk(clk), .reset(reset), .q(q8));

  ring_counter #(.WIDTH(4), .RESET_VALUE(4'b0110)) umh (.clk(clk), .reset(reset), .q(qmh));

  ring_counter #(.WIDTH(4), .RESET_VALUE(4'b0000)) uz (.clk(clk), .reset(reset), .q(qz));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] e4, input logic [7:0] e8,
                      input logic [3:0] emh, input logic [3:0] ez);
    exp_t e;
    e.tag = tag;
    e.e4  = e4;
    e.e8  = e8;
    e.emh = emh;
    e.ez  = ez;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_q4"},  32'(q4),  32'(e.e4));
      check({e.tag, "_q8"},  32'(q8),  32'(e.e8));
      check({e.tag, "_qmh"}, 32'(qmh), 32'(e.emh));
      check({e.tag, "_qz"},  32'(qz),  32'(e.ez));
    end
  endtask

  task automatic expect_edge(input string tag, input logic [3:0] e4, input logic [7:0] e8,
                             input logic [3:0] emh, input logic [3:0] ez);
    push(tag, e4, e8, emh, ez);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  logic [3:0] seq4[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] seq8[8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
`ifdef RING_COUNTER_SELF_CORRECT_EN
  // Illegal multi-hot reset value is itself non-one-hot, so it is reloaded every edge.
  logic [3:0] seqmh[4] = '{4'b0110, 4'b0110, 4'b0110, 4'b0110};
`else
  logic [3:0] seqmh[4] = '{4'b1100, 4'b1001, 4'b0011, 4'b0110};
`endif

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    #1;
    push("rst_async", 4'b0001, 8'h01, 4'b0110, 4'b0000);
    pop_check();
    expect_edge("rst_hold", 4'b0001, 8'h01, 4'b0110, 4'b0000);

    #4 reset = 1'b0;  // t=10
    for (int i = 0; i < 5; i++) begin
      expect_edge($sformatf("run1_%0d", i), seq4[i % 4], seq8[i % 8], seqmh[i % 4], 4'b0000);
    end

    #4 reset = 1'b1;  // t=60, between edges
    push("rst_mid", 4'b0001, 8'h01, 4'b0110, 4'b0000);
    #1;
    pop_check();
    expect_edge("rst_mid_hold", 4'b0001, 8'h01, 4'b0110, 4'b0000);

    #4 reset = 1'b0;  // t=70
    for (int i = 0; i < 9; i++) begin
      expect_edge($sformatf("run2_%0d", i), seq4[i % 4], seq8[i % 8], seqmh[i % 4], 4'b0000);
    end

    if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
